// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between the writeback sources (pipeline, MDU) and the register-file write-port arbiter.
// The master drives the write requests; the arbiter (slave) returns the port signals and back-pressure.
interface regfile_wb_arbiter_if;
   logic        pipe_we;
   logic [4:0]  pipe_addr;
   logic [31:0] pipe_data;
   logic        mdu_valid;
   logic [4:0]  mdu_addr;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic        stall;
   logic        regWrite;
   logic [4:0]  addr3;
   logic [31:0] din;
   logic [31:0] pending_mask;

   modport master (
      output pipe_we, pipe_addr, pipe_data, mdu_valid, mdu_addr, mdu_data,
      input  mdu_ready, stall, regWrite, addr3, din, pending_mask
   );

   modport slave (
      input  pipe_we, pipe_addr, pipe_data, mdu_valid, mdu_addr, mdu_data,
      output mdu_ready, stall, regWrite, addr3, din, pending_mask
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between pipeline writeback and a queued MDU.
// Pipeline has priority; a starvation counter forces the MDU FIFO head through after STARVE_LIMIT denials.
module regfile_wb_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_wb_arbiter_if.slave  bus
);
   localparam int DATA_W = 32;
   localparam int AW     = 5;
   localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW     = $clog2(DEPTH + 1);
   localparam int SW     = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {
      GR_IDLE,
      GR_FORCE,
      GR_PIPE,
      GR_DRAIN,
      GR_BYPASS
   } grant_e;

   logic [AW-1:0]     fifo_addr [DEPTH];
   logic [DATA_W-1:0] fifo_data [DEPTH];
   logic [DEPTH-1:0]  vld;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic [CW-1:0]     count;
   logic [CW-1:0]     count_nxt;
   logic [SW-1:0]     cnt;

   grant_e            grant;
   logic              pipe_req;
   logic              mdu_ready_c;
   logic              mdu_live;
   logic              starve_force;
   logic              push;
   logic              pop;
   logic              regwrite_c;
   logic [AW-1:0]     addr3_c;
   logic [DATA_W-1:0] din_c;
   logic              stall_c;
   logic [31:0]       mask_c;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Request qualification and grant selection
   always_comb begin
      mdu_ready_c  = !rst && (count < CW'(DEPTH));
      pipe_req     = bus.pipe_we && (bus.pipe_addr != '0);
      mdu_live     = bus.mdu_valid && mdu_ready_c && (bus.mdu_addr != '0);
      starve_force = (cnt == SW'(STARVE_LIMIT)) && (count != '0);
      grant        = GR_IDLE;
      if (rst)                grant = GR_IDLE;
      else if (starve_force)  grant = GR_FORCE;
      else if (pipe_req)      grant = GR_PIPE;
      else if (count != '0)   grant = GR_DRAIN;
      else if (mdu_live)      grant = GR_BYPASS;
   end

   assign pop  = (grant == GR_FORCE) || (grant == GR_DRAIN);
   assign push = mdu_live && (grant != GR_BYPASS);

   always_comb begin
      regwrite_c = 1'b0;
      addr3_c    = '0;
      din_c      = '0;
      stall_c    = 1'b0;
      unique case (grant)
         GR_FORCE: begin
            regwrite_c = 1'b1;
            addr3_c    = fifo_addr[rd_ptr];
            din_c      = fifo_data[rd_ptr];
            stall_c    = pipe_req;
         end
         GR_PIPE: begin
            regwrite_c = 1'b1;
            addr3_c    = bus.pipe_addr;
            din_c      = bus.pipe_data;
         end
         GR_DRAIN: begin
            regwrite_c = 1'b1;
            addr3_c    = fifo_addr[rd_ptr];
            din_c      = fifo_data[rd_ptr];
         end
         GR_BYPASS: begin
            regwrite_c = 1'b1;
            addr3_c    = bus.mdu_addr;
            din_c      = bus.mdu_data;
         end
         default: ;
      endcase
   end

   // Queued destinations; r0 is never enqueued so bit 0 stays clear.
   always_comb begin
      mask_c = '0;
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (vld[i]) mask_c[fifo_addr[i]] = 1'b1;
         end
      end
   end

   always_comb begin
      count_nxt = count;
      if (push && !pop)      count_nxt = count + 1'b1;
      else if (pop && !push) count_nxt = count - 1'b1;
   end

   // FIFO control and starvation counter state
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         vld    <= '0;
         cnt    <= '0;
      end else begin
         count <= count_nxt;
         if (pop) begin
            rd_ptr      <= ptr_inc(rd_ptr);
            vld[rd_ptr] <= 1'b0;
         end
         if (push) begin
            wr_ptr      <= ptr_inc(wr_ptr);
            vld[wr_ptr] <= 1'b1;
         end
         if (pop || (count_nxt == '0))
            cnt <= '0;
         else if ((count != '0) && (cnt != SW'(STARVE_LIMIT)))
            cnt <= cnt + 1'b1;
      end
   end

   // FIFO payload storage, qualified by vld so it needs no reset
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= bus.mdu_addr;
         fifo_data[wr_ptr] <= bus.mdu_data;
      end
   end

   assign bus.mdu_ready    = mdu_ready_c;
   assign bus.stall        = stall_c;
   assign bus.regWrite     = regwrite_c;
   assign bus.addr3        = addr3_c;
   assign bus.din          = din_c;
   assign bus.pending_mask = mask_c;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a queue-based model checked every cycle,
// plus literal expectations at the scenario points.
module tb_regfile_wb_arbiter;
   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   regfile_wb_arbiter_if bus();

   regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit done   = 1'b0;

   logic [4:0]  mq_a [$];
   logic [31:0] mq_d [$];
   int          waited = 0;
   logic [4:0]  wlog [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: queue of pending MDU results, evaluated mid-cycle
   always @(negedge clk) begin : model
      logic        e_we, e_stall, e_rdy;
      logic [4:0]  e_a;
      logic [31:0] e_d, e_mask;
      bit          preq, live, byp, popd, had;
      if (!done) begin
         e_we = 0; e_stall = 0; e_rdy = 0; e_a = 0; e_d = 0; e_mask = 0;
         preq = 0; live = 0; byp = 0; popd = 0; had = 0;
         if (!rst) begin
            e_rdy = (mq_a.size() < DEPTH);
            foreach (mq_a[i]) e_mask[mq_a[i]] = 1'b1;
            preq = bus.pipe_we && (bus.pipe_addr != 5'd0);
            live = bus.mdu_valid && e_rdy && (bus.mdu_addr != 5'd0);
            had  = (mq_a.size() > 0);
            if (had && waited >= LIMIT) begin
               e_we = 1; e_a = mq_a[0]; e_d = mq_d[0]; e_stall = preq; popd = 1;
            end else if (preq) begin
               e_we = 1; e_a = bus.pipe_addr; e_d = bus.pipe_data;
            end else if (had) begin
               e_we = 1; e_a = mq_a[0]; e_d = mq_d[0]; popd = 1;
            end else if (live) begin
               e_we = 1; e_a = bus.mdu_addr; e_d = bus.mdu_data; byp = 1;
            end
         end
         chk("m_regWrite", {31'd0, bus.regWrite}, {31'd0, e_we});
         chk("m_addr3", {27'd0, bus.addr3}, {27'd0, e_a});
         chk("m_din", bus.din, e_d);
         chk("m_stall", {31'd0, bus.stall}, {31'd0, e_stall});
         chk("m_mdu_ready", {31'd0, bus.mdu_ready}, {31'd0, e_rdy});
         chk("m_pending_mask", bus.pending_mask, e_mask);
         if (bus.regWrite === 1'b1 && bus.addr3 >= 5'd10 && bus.addr3 <= 5'd12)
            wlog.push_back(bus.addr3);
         if (rst) begin
            mq_a.delete(); mq_d.delete(); waited = 0;
         end else begin
            if (popd) begin
               void'(mq_a.pop_front());
               void'(mq_d.pop_front());
            end
            if (live && !byp) begin
               mq_a.push_back(bus.mdu_addr);
               mq_d.push_back(bus.mdu_data);
            end
            if (popd || mq_a.size() == 0) waited = 0;
            else if (had)                 waited = (waited + 1 > LIMIT) ? LIMIT : waited + 1;
         end
      end
   end

   initial begin
      int n;
      bus.pipe_we = 1; bus.pipe_addr = 5'd3; bus.pipe_data = 32'h0000_0BAD;
      bus.mdu_valid = 1; bus.mdu_addr = 5'd5; bus.mdu_data = 32'h5555_5555;
      rst = 1;

      // reset with both requesters active
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_regWrite", {31'd0, bus.regWrite}, 32'd0);
         chk("rst_mdu_ready", {31'd0, bus.mdu_ready}, 32'd0);
         step();
      end
      rst = 0; bus.pipe_we = 0; bus.mdu_valid = 0;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, bus.mdu_ready}, 32'd1);
      chk("post_rst_mask", bus.pending_mask, 32'd0);
      step();

      // bypass on an empty FIFO
      bus.mdu_valid = 1; bus.mdu_addr = 5'd5; bus.mdu_data = 32'h1111_1111;
      @(negedge clk);
      chk("byp_regWrite", {31'd0, bus.regWrite}, 32'd1);
      chk("byp_addr3", {27'd0, bus.addr3}, 32'd5);
      chk("byp_din", bus.din, 32'h1111_1111);
      chk("byp_mask", bus.pending_mask, 32'd0);
      step();
      bus.mdu_valid = 0;
      @(negedge clk);
      chk("byp_mask_after", bus.pending_mask, 32'd0);
      step();

      // pipeline priority, then drain
      bus.pipe_we = 1; bus.pipe_addr = 5'd3; bus.pipe_data = 32'h1234_5678;
      bus.mdu_valid = 1; bus.mdu_addr = 5'd7; bus.mdu_data = 32'hAAAA_0001;
      @(negedge clk);
      chk("pri_addr3", {27'd0, bus.addr3}, 32'd3);
      chk("pri_din", bus.din, 32'h1234_5678);
      step();
      bus.mdu_valid = 0;
      @(negedge clk);
      chk("pri_mask", bus.pending_mask, 32'h0000_0080);
      chk("pri_addr3_hold", {27'd0, bus.addr3}, 32'd3);
      step();
      bus.pipe_we = 0;
      @(negedge clk);
      chk("drain_addr3", {27'd0, bus.addr3}, 32'd7);
      chk("drain_din", bus.din, 32'hAAAA_0001);
      step();
      @(negedge clk);
      chk("drain_mask_clear", bus.pending_mask, 32'd0);
      chk("drain_idle", {31'd0, bus.regWrite}, 32'd0);
      step();

      // starvation guard
      bus.pipe_we = 1; bus.pipe_addr = 5'd3; bus.pipe_data = 32'h0000_0033;
      bus.mdu_valid = 1; bus.mdu_addr = 5'd9; bus.mdu_data = 32'h9999_9999;
      @(negedge clk);
      chk("stv_enq_addr3", {27'd0, bus.addr3}, 32'd3);
      step();
      bus.mdu_valid = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("stv_nostall", {31'd0, bus.stall}, 32'd0);
         chk("stv_pipe_addr3", {27'd0, bus.addr3}, 32'd3);
         step();
      end
      @(negedge clk);
      chk("stv_stall", {31'd0, bus.stall}, 32'd1);
      chk("stv_force_addr3", {27'd0, bus.addr3}, 32'd9);
      chk("stv_force_din", bus.din, 32'h9999_9999);
      step();
      @(negedge clk);
      chk("stv_resume_stall", {31'd0, bus.stall}, 32'd0);
      chk("stv_resume_addr3", {27'd0, bus.addr3}, 32'd3);
      chk("stv_resume_mask", bus.pending_mask, 32'd0);
      step();
      bus.pipe_we = 0;
      step();

      // full FIFO under continuous pipeline traffic
      wlog.delete();
      bus.pipe_we = 1; bus.pipe_addr = 5'd3;
      for (int k = 0; k < 3; k++) begin
         bus.mdu_valid = 1;
         bus.mdu_addr  = 5'(10 + k);
         bus.mdu_data  = 32'hC000_0000 + 32'(k);
         n = 0;
         @(negedge clk);
         if (k == 2) chk("full_ready_low", {31'd0, bus.mdu_ready}, 32'd0);
         while (bus.mdu_ready !== 1'b1 && n < 40) begin
            step();
            @(negedge clk);
            n++;
         end
         if (n >= 40) chk("full_accept_timeout", 32'd0, 32'd1);
         if (k == 2) chk("full_held_cycles", 32'(n), 32'd4);
         step();
      end
      bus.mdu_valid = 0;
      n = 0;
      @(negedge clk);
      while (bus.pending_mask !== 32'd0 && n < 60) begin
         step();
         @(negedge clk);
         n++;
      end
      if (n >= 60) chk("full_drain_timeout", 32'd0, 32'd1);
      step();
      bus.pipe_we = 0;
      step();
      chk("full_wcount", 32'(wlog.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         chk("full_order", (i < wlog.size()) ? {27'd0, wlog[i]} : 32'hFFFF_FFFF, 32'(10 + i));

      // r0 handling
      bus.pipe_we = 1; bus.pipe_addr = 5'd3;
      bus.mdu_valid = 1; bus.mdu_addr = 5'd4; bus.mdu_data = 32'h4444_4444;
      step();
      bus.mdu_valid = 0; bus.pipe_addr = 5'd0; bus.pipe_data = 32'h0000_DEAD;
      @(negedge clk);
      chk("r0_regWrite", {31'd0, bus.regWrite}, 32'd1);
      chk("r0_addr3", {27'd0, bus.addr3}, 32'd4);
      chk("r0_din", bus.din, 32'h4444_4444);
      chk("r0_stall", {31'd0, bus.stall}, 32'd0);
      step();
      bus.pipe_we = 0;
      bus.mdu_valid = 1; bus.mdu_addr = 5'd0; bus.mdu_data = 32'hFFFF_0000;
      @(negedge clk);
      chk("r0_mdu_ready", {31'd0, bus.mdu_ready}, 32'd1);
      chk("r0_mdu_nowrite", {31'd0, bus.regWrite}, 32'd0);
      chk("r0_mdu_mask", bus.pending_mask, 32'd0);
      step();
      bus.mdu_valid = 0;
      @(negedge clk);
      chk("r0_mdu_mask_after", bus.pending_mask, 32'd0);
      chk("r0_mdu_nowrite_after", {31'd0, bus.regWrite}, 32'd0);
      step();

      // reset while an entry is queued
      bus.pipe_we = 1; bus.pipe_addr = 5'd3;
      bus.mdu_valid = 1; bus.mdu_addr = 5'd20; bus.mdu_data = 32'h2020_2020;
      step();
      bus.mdu_valid = 0;
      @(negedge clk);
      chk("mid_mask", bus.pending_mask, 32'h0010_0000);
      step();
      rst = 1;
      @(negedge clk);
      chk("mid_rst_regWrite", {31'd0, bus.regWrite}, 32'd0);
      chk("mid_rst_stall", {31'd0, bus.stall}, 32'd0);
      chk("mid_rst_mask", bus.pending_mask, 32'd0);
      chk("mid_rst_ready", {31'd0, bus.mdu_ready}, 32'd0);
      step();
      rst = 0; bus.pipe_we = 0;
      @(negedge clk);
      chk("mid_post_regWrite", {31'd0, bus.regWrite}, 32'd0);
      chk("mid_post_mask", bus.pending_mask, 32'd0);
      chk("mid_post_ready", {31'd0, bus.mdu_ready}, 32'd1);
      step();

      done = 1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end
endmodule
